hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 89 ++++++++
 tb/tb_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-redirect detection, a multi-cycle
// stall sequencer for long-latency execute ops, and the delayed flags and held word for IF/ID.
module hazard_ctrl #(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdE,
  input  logic        LoadE,
  input  logic        PCSrcE,
  input  logic        MdStartE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        stall_1d,
  output logic        flush_1d,
  output logic [31:0] inst_tmp_1d,
  output logic        md_busy
);

  typedef enum logic {IDLE, BUSY} mdState_t;

  localparam logic [3:0] MdLoad = 4'(MD_LAT - 1);

  mdState_t   state;
  logic [3:0] md_cnt;
  logic       lwStall;
  logic       mdStall;

  // A load writing x0 never creates a dependency.
  assign lwStall = LoadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign md_busy = (state == BUSY);
  assign mdStall = md_busy;

  assign StallF = lwStall | mdStall;
  assign StallD = lwStall | mdStall;
  assign StallE = mdStall;

  // While the long op is frozen in E its PCSrcE/LoadE are stale, so every flush is masked.
  assign FlushD = PCSrcE & ~mdStall;
  assign FlushE = (lwStall & ~mdStall) | (PCSrcE & ~mdStall);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      md_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (MdStartE) begin
            state  <= BUSY;
            md_cnt <= MdLoad;
          end
        end
        BUSY: begin
          md_cnt <= md_cnt - 4'd1;
          if (md_cnt == 4'd1) begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          md_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Capture only on the first stall cycle; later the memory returns the F-stage word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_1d    <= 1'b0;
      flush_1d    <= 1'b0;
      inst_tmp_1d <= 32'h0000_0000;
    end else begin
      stall_1d <= StallD;
      flush_1d <= FlushD;
      if (StallD && !stall_1d) begin
        inst_tmp_1d <= instr;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MD_LAT = 4.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  RdE;
  logic        LoadE;
  logic        PCSrcE;
  logic        MdStartE;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        FlushD;
  logic        FlushE;
  logic        stall_1d;
  logic        flush_1d;
  logic [31:0] inst_tmp_1d;
  logic        md_busy;

  int checkCount = 0;
  int passCount  = 0;

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr      (instr),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdE        (RdE),
    .LoadE      (LoadE),
    .PCSrcE     (PCSrcE),
    .MdStartE   (MdStartE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .stall_1d   (stall_1d),
    .flush_1d   (flush_1d),
    .inst_tmp_1d(inst_tmp_1d),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic pcs, input logic mds,
                               input logic [31:0] ins);
    @(negedge clk);
    LoadE    = ld;
    RdE      = rd;
    Rs1D     = rs1;
    Rs2D     = rs2;
    PCSrcE   = pcs;
    MdStartE = mds;
    instr    = ins;
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    LoadE    = 1'b0;
    RdE      = 5'd0;
    Rs1D     = 5'd0;
    Rs2D     = 5'd0;
    PCSrcE   = 1'b0;
    MdStartE = 1'b0;
    instr    = 32'h0;
    #3;
    checkOutput("rst_stall_1d", 32'(stall_1d), 32'd0);
    checkOutput("rst_flush_1d", 32'(flush_1d), 32'd0);
    checkOutput("rst_inst_tmp", inst_tmp_1d, 32'h0);
    checkOutput("rst_md_busy", 32'(md_busy), 32'd0);
    checkOutput("rst_stallf", 32'(StallF), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Load-use on rs1
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0062_8333);
    checkOutput("lu_stallf", 32'(StallF), 32'd1);
    checkOutput("lu_stalld", 32'(StallD), 32'd1);
    checkOutput("lu_flushe", 32'(FlushE), 32'd1);
    checkOutput("lu_flushd", 32'(FlushD), 32'd0);
    checkOutput("lu_stalle", 32'(StallE), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h1111_1111);
    checkOutput("lu_stall_1d", 32'(stall_1d), 32'd1);
    checkOutput("lu_inst_tmp", inst_tmp_1d, 32'h0062_8333);
    checkOutput("lu_stalld_clr", 32'(StallD), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h2222_2222);
    checkOutput("lu_stall_1d_clr", 32'(stall_1d), 32'd0);
    checkOutput("lu_inst_hold", inst_tmp_1d, 32'h0062_8333);

    // x0 immunity, no-match, non-load match, rs2 match
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("x0_stalld", 32'(StallD), 32'd0);
    checkOutput("x0_flushe", 32'(FlushE), 32'd0);
    applyStimulus(1'b1, 5'd9, 5'd3, 5'd4, 1'b0, 1'b0, 32'h0);
    checkOutput("nomatch_stalld", 32'(StallD), 32'd0);
    applyStimulus(1'b0, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 32'h0);
    checkOutput("noload_stalld", 32'(StallD), 32'd0);
    applyStimulus(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 32'h0);
    checkOutput("rs2_stalld", 32'(StallD), 32'd1);
    checkOutput("rs2_flushe", 32'(FlushE), 32'd1);

    // Branch redirect
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0);
    checkOutput("br_flushd", 32'(FlushD), 32'd1);
    checkOutput("br_flushe", 32'(FlushE), 32'd1);
    checkOutput("br_stalld", 32'(StallD), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("br_flush_1d", 32'(flush_1d), 32'd1);
    checkOutput("br_flushd_clr", 32'(FlushD), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("br_flush_1d_clr", 32'(flush_1d), 32'd0);

    // Long op, MD_LAT = 4: start at t, busy t+1..t+3
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0);
    checkOutput("md_t_busy", 32'(md_busy), 32'd0);
    checkOutput("md_t_stalld", 32'(StallD), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'hAAAA_0001);
    checkOutput("md_t1_busy", 32'(md_busy), 32'd1);
    checkOutput("md_t1_stalle", 32'(StallE), 32'd1);
    checkOutput("md_t1_stalld", 32'(StallD), 32'd1);
    checkOutput("md_t1_stall_1d", 32'(stall_1d), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'hBBBB_0002);
    checkOutput("md_t2_flushd", 32'(FlushD), 32'd0);
    checkOutput("md_t2_flushe", 32'(FlushE), 32'd0);
    checkOutput("md_t2_stallf", 32'(StallF), 32'd1);
    checkOutput("md_t2_inst_tmp", inst_tmp_1d, 32'hAAAA_0001);
    checkOutput("md_t2_stall_1d", 32'(stall_1d), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'hCCCC_0003);
    checkOutput("md_t3_busy", 32'(md_busy), 32'd1);
    checkOutput("md_t3_stallf", 32'(StallF), 32'd1);
    checkOutput("md_t3_inst_tmp", inst_tmp_1d, 32'hAAAA_0001);
    checkOutput("md_t3_flush_1d", 32'(flush_1d), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("md_t4_busy", 32'(md_busy), 32'd0);
    checkOutput("md_t4_stallf", 32'(StallF), 32'd0);
    checkOutput("md_t4_stalle", 32'(StallE), 32'd0);
    checkOutput("md_t4_stall_1d", 32'(stall_1d), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("md_t5_stall_1d", 32'(stall_1d), 32'd0);
    checkOutput("md_t5_busy", 32'(md_busy), 32'd0);

    // Simultaneous load-use and redirect
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 32'h0);
    checkOutput("sim_stalld", 32'(StallD), 32'd1);
    checkOutput("sim_flushd", 32'(FlushD), 32'd1);
    checkOutput("sim_flushe", 32'(FlushE), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);

    // Reset asserted during the long-op sequence
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'hDDDD_0004);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("rstmd_pre_busy", 32'(md_busy), 32'd1);
    checkOutput("rstmd_pre_inst", inst_tmp_1d, 32'hDDDD_0004);
    reset_n = 1'b0;
    #1;
    checkOutput("rstmd_busy", 32'(md_busy), 32'd0);
    checkOutput("rstmd_stall_1d", 32'(stall_1d), 32'd0);
    checkOutput("rstmd_inst_tmp", inst_tmp_1d, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("rstmd_post_stallf", 32'(StallF), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("rstmd_post2_stallf", 32'(StallF), 32'd0);
    checkOutput("rstmd_post2_busy", 32'(md_busy), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
